// File: rtl/shift_add_multiplier_8x8_pkg.sv
// rtl/shift_add_multiplier_8x8_pkg.sv - shared state encoding and iteration constants
package shift_add_multiplier_8x8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int         ITERATIONS = 8;
    localparam logic [3:0] LAST_COUNT = 4'(ITERATIONS - 1);

endpackage

// File: rtl/eight_bit_adder.sv
// rtl/eight_bit_adder.sv - combinational 8-bit adder with carry in/out
module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

// File: rtl/shift_add_multiplier_8x8.sv
// rtl/shift_add_multiplier_8x8.sv - sequential unsigned 8x8 shift-and-add multiplier
module shift_add_multiplier_8x8
    import shift_add_multiplier_8x8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    mul_state_t         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [3:0]         count_q;
    logic [2*WIDTH-1:0] product_q;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] shifted;

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    eight_bit_adder u_adder (
        .a     (acc_hi_q),
        .b     (addend),
        .cin   (1'b0),
        .sum   (sum),
        .carry (carry)
    );

    // The adder carry becomes the new top bit, so no partial-sum bit is lost.
    assign shifted   = {carry, sum, acc_lo_q[WIDTH-1:1]};
    assign last_iter = (state_q == ST_RUN) && (count_q == LAST_COUNT);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (count_q == LAST_COUNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                accept  = start;
                state_d = start ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mcand_q  <= multiplicand;
                acc_hi_q <= '0;
                acc_lo_q <= multiplier;
                count_q  <= '0;
            end else if (state_q == ST_RUN) begin
                acc_hi_q <= shifted[2*WIDTH-1:WIDTH];
                acc_lo_q <= shifted[WIDTH-1:0];
                count_q  <= count_q + 4'd1;
            end
            if (last_iter) begin
                product_q <= shifted;
            end
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier_8x8.sv
// tb/tb_shift_add_multiplier_8x8.sv - randomized self-checking bench with behavioural model
module tb_shift_add_multiplier_8x8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  multiplicand = 8'd0;
    logic [7:0]  multiplier = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int vectors = 0;
    int errors  = 0;
    bit check_en = 1'b0;

    // Behavioural model: an operation is a countdown of 8 busy cycles ending in a done cycle.
    int          m_rem = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int unsigned m_a = 0;
    int unsigned m_b = 0;
    int unsigned m_prod = 0;

    shift_add_multiplier_8x8 dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_prod = 0;
        end else begin
            m_done = 1'b0;
            if (m_rem != 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_prod = m_a * m_b;
                end
            end else if (start) begin
                m_rem  = 8;
                m_busy = 1'b1;
                m_a    = multiplicand;
                m_b    = multiplier;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("product", {16'd0, product}, m_prod);
            if (busy && done) chk("busy_done_overlap", 32'd1, 32'd0);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    // Issue one operation and watch a fixed window for its single done pulse.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input bit junk);
        int nb, lat, dones;
        bit seen;
        nb = 0; lat = 0; dones = 0; seen = 1'b0;
        @(posedge clk); #1; start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                dones++;
                if (!seen) begin
                    seen = 1'b1;
                    lat = i;
                    chk("op_product", {16'd0, product}, {16'd0, exp});
                    chk("model_product", m_prod, {16'd0, exp});
                end
            end
            if (junk && i == 3) begin
                start = 1'b1;
                multiplicand = 8'($urandom_range(255));
                multiplier = 8'($urandom_range(255));
            end else if (junk && i == 4) begin
                start = 1'b0;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("done_latency", lat, 32'd9);
        chk("busy_cycles", nb, 32'd8);
        chk("done_count", dones, 32'd1);
    endtask

    initial begin
        int nd, lat;
        logic [7:0] ra, rb;

        do_reset();
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_product", {16'd0, product}, 32'd0);

        run_op(8'd255, 8'd255, 16'd65025, 1'b0);
        run_op(8'd200, 8'd200, 16'd40000, 1'b0);
        run_op(8'd0,   8'd173, 16'd0,     1'b0);
        run_op(8'd1,   8'd1,   16'd1,     1'b0);
        run_op(8'd128, 8'd2,   16'd256,   1'b0);
        run_op(8'd15,  8'd17,  16'd255,   1'b0);

        // start pulse during RUN with new operands must be ignored
        run_op(8'd255, 8'd255, 16'd65025, 1'b1);

        // reset in the middle of 100 x 100 aborts with no done pulse
        @(posedge clk); #1; start = 1'b1; multiplicand = 8'd100; multiplier = 8'd100;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", {16'd0, product}, 32'd0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 32'd0);

        // back-to-back: second start issued in the DONE cycle
        @(posedge clk); #1; start = 1'b1; multiplicand = 8'd10; multiplier = 8'd20;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (done) lat = i;
        end
        chk("b2b_first_latency", lat, 32'd9);
        chk("b2b_first_product", {16'd0, product}, 32'd200);
        start = 1'b1; multiplicand = 8'd79; multiplier = 8'd80;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (done) lat = i;
        end
        chk("b2b_second_latency", lat, 32'd9);
        chk("b2b_second_product", {16'd0, product}, 32'd6320);

        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            run_op(ra, rb, 16'(32'(ra) * 32'(rb)), ($urandom_range(3) == 0));
            repeat ($urandom_range(3)) @(posedge clk);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
